// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the instruction-ROM bus, the execute redirect
// request, the decode-side valid/ready handshake and the trap status of the
// fetch stage.
//   imem_addr / imem_rdata        : ROM word address out, instruction back
//   redirect_valid / redirect_pc  : PC reload request from execute
//   out_valid / out_ready         : decode handshake
//   out_instr / out_pc            : head instruction and its byte address
//   trap / trap_pc                : halted on misaligned redirect target
// master = fetch stage, slave = its environment (ROM + execute + decode).
interface instr_fetch_if #(
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned DWIDTH = 32
);
    logic [AWIDTH-1:0] imem_addr;
    logic [DWIDTH-1:0] imem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_instr;
    logic [31:0]       out_pc;
    logic              trap;
    logic [31:0]       trap_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output trap,
        output trap_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  trap,
        input  trap_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage. Holds the PC, addresses the
// combinational instruction ROM, captures {pc, instr} into a 2-entry FIFO
// and presents the head to decode over valid/ready. Redirects from execute
// flush the FIFO and reload the PC; a misaligned target halts fetch (TRAP)
// until an aligned redirect or reset.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : instr_fetch_if.master (ROM, redirect, decode handshake, trap)
module instr_fetch #(
    parameter int unsigned AWIDTH   = 8,
    parameter int unsigned DWIDTH   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_if.master     bus
);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic [31:0]       trap_pc_q, trap_pc_d;
    logic [31:0]       buf_pc_q    [2];
    logic [DWIDTH-1:0] buf_instr_q [2];

    logic              push;
    logic              pop;
    logic              wr_idx;
    logic              out_valid;

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & bus.out_ready;
    assign push      = (state_q == RUN) & ~bus.redirect_valid
                     & ((count_q != 2'd2) | pop);
    // Tail slot: head when empty or full (full only pushes alongside a pop,
    // so the slot being freed is the one rewritten), the other slot otherwise.
    assign wr_idx    = head_q ^ count_q[0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        head_d    = head_q;
        trap_pc_d = trap_pc_q;

        if (bus.redirect_valid) begin
            // Redirect wins over push and pop; a same-cycle pop is flushed too.
            pc_d    = bus.redirect_pc;
            count_d = '0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state_d   = TRAP;
                trap_pc_d = bus.redirect_pc;
            end else begin
                state_d   = RUN;
                trap_pc_d = '0;
            end
        end else begin
            if (push) begin
                pc_d = pc_q + 32'd4;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            count_q   <= '0;
            head_q    <= 1'b0;
            trap_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            count_q   <= count_d;
            head_q    <= head_d;
            trap_pc_q <= trap_pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
            end
        end else if (push) begin
            buf_pc_q[wr_idx]    <= pc_q;
            buf_instr_q[wr_idx] <= bus.imem_rdata;
        end
    end

    assign bus.imem_addr = pc_q[AWIDTH+1:2];
    assign bus.out_valid = out_valid;
    assign bus.out_instr = out_valid ? buf_instr_q[head_q] : DWIDTH'(32'h0000_0013);
    assign bus.out_pc    = out_valid ? buf_pc_q[head_q] : 32'h0;
    assign bus.trap      = (state_q == TRAP);
    assign bus.trap_pc   = trap_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    instr_fetch_if #(.AWIDTH(8), .DWIDTH(32)) bus ();

    instr_fetch #(
        .AWIDTH  (8),
        .DWIDTH  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ROM model: word k holds 32'h1000_0000 + k
    assign bus.imem_rdata = 32'h1000_0000 + {24'h0, bus.imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        @(posedge clk);
        #2;
        rst_n              = 1'b0;
        bus.out_ready      = ready;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        rst_n              = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // reset state
        #12;
        check("rst_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_instr", bus.out_instr, 32'h0000_0013);
        check("rst_pc", bus.out_pc, 32'h0);
        check("rst_trap", {31'h0, bus.trap}, 32'h0);
        check("rst_trap_pc", bus.trap_pc, 32'h0);
        check("rst_addr", {24'h0, bus.imem_addr}, 32'h0);

        // streaming with out_ready=1
        rst_n = 1'b1;
        check("pre_edge_valid", {31'h0, bus.out_valid}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("stream_valid", {31'h0, bus.out_valid}, 32'h1);
            check("stream_pc", bus.out_pc, 32'(4 * k));
            check("stream_instr", bus.out_instr, 32'h1000_0000 + 32'(k));
        end

        // back-pressure
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_pc_hold", bus.out_pc, 32'h0);
            check("bp_instr_hold", bus.out_instr, 32'h1000_0000);
        end
        check("bp_addr", {24'h0, bus.imem_addr}, 32'h2);
        check("bp_valid", {31'h0, bus.out_valid}, 32'h1);
        bus.out_ready = 1'b1;
        for (int k = 1; k < 6; k++) begin
            step();
            check("bp_drain_valid", {31'h0, bus.out_valid}, 32'h1);
            check("bp_drain_pc", bus.out_pc, 32'(4 * k));
            check("bp_drain_instr", bus.out_instr, 32'h1000_0000 + 32'(k));
        end

        // redirect while full with out_ready=1
        bus.out_ready = 1'b0;
        step();
        step();
        bus.out_ready = 1'b1;
        redirect(32'h0000_0040);
        check("redir_flush_valid", {31'h0, bus.out_valid}, 32'h0);
        check("redir_flush_instr", bus.out_instr, 32'h0000_0013);
        check("redir_addr", {24'h0, bus.imem_addr}, 32'h10);
        step();
        check("redir_valid", {31'h0, bus.out_valid}, 32'h1);
        check("redir_pc0", bus.out_pc, 32'h40);
        check("redir_instr0", bus.out_instr, 32'h1000_0010);
        step();
        check("redir_pc1", bus.out_pc, 32'h44);
        check("redir_instr1", bus.out_instr, 32'h1000_0011);

        // misaligned redirect -> trap
        redirect(32'h0000_0042);
        check("trap_set", {31'h0, bus.trap}, 32'h1);
        check("trap_pc", bus.trap_pc, 32'h42);
        check("trap_valid", {31'h0, bus.out_valid}, 32'h0);
        check("trap_addr", {24'h0, bus.imem_addr}, 32'h10);
        for (int k = 0; k < 3; k++) begin
            step();
            check("trap_hold_valid", {31'h0, bus.out_valid}, 32'h0);
            check("trap_hold", {31'h0, bus.trap}, 32'h1);
        end
        redirect(32'h0000_0045);
        check("trap_pc_update", bus.trap_pc, 32'h45);
        check("trap_still", {31'h0, bus.trap}, 32'h1);
        redirect(32'h0000_0080);
        check("trap_clear", {31'h0, bus.trap}, 32'h0);
        check("trap_pc_clear", bus.trap_pc, 32'h0);
        check("trap_exit_valid", {31'h0, bus.out_valid}, 32'h0);
        step();
        check("trap_exit_pc", bus.out_pc, 32'h80);
        check("trap_exit_instr", bus.out_instr, 32'h1000_0020);

        // PC wrap and address aliasing
        redirect(32'hFFFF_FFFC);
        check("wrap_addr_ff", {24'h0, bus.imem_addr}, 32'hFF);
        check("wrap_valid0", {31'h0, bus.out_valid}, 32'h0);
        step();
        check("wrap_pc_top", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap_instr_top", bus.out_instr, 32'h1000_00FF);
        check("wrap_addr_0", {24'h0, bus.imem_addr}, 32'h0);
        step();
        check("wrap_pc_zero", bus.out_pc, 32'h0);
        check("wrap_instr_zero", bus.out_instr, 32'h1000_0000);

        // asynchronous reset mid-stream with a full buffer
        bus.out_ready = 1'b0;
        step();
        step();
        step();
        check("pre_arst_valid", {31'h0, bus.out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, bus.out_valid}, 32'h0);
        check("arst_trap", {31'h0, bus.trap}, 32'h0);
        check("arst_addr", {24'h0, bus.imem_addr}, 32'h0);
        check("arst_pc", bus.out_pc, 32'h0);
        step();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("post_arst_pc", bus.out_pc, 32'h0);
        check("post_arst_instr", bus.out_instr, 32'h1000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the simplified RISC-V core, sitting directly upstream of the combinational instruction ROM and downstream-feeding the decode stage. Holds the program counter, drives the ROM word address, captures the returned instruction with its PC into a 2-entry buffer, and presents it to decode over a valid/ready handshake. Handles control-flow redirects from execute (flush + PC reload) and traps on misaligned redirect targets.

## Interface
- AWIDTH, 8, instruction ROM word-address width
- DWIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous assertion, active-low
- imem_addr  out  AWIDTH  ROM word address = pc[AWIDTH+1:2]
- imem_rdata  in  DWIDTH  ROM read data, valid combinationally in the same cycle as imem_addr
- redirect_valid  in  1  load new PC this cycle (branch/jump taken)
- redirect_pc  in  32  redirect target byte address
- out_valid  out  1  buffer head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  DWIDTH  head instruction; 32'h0000_0013 (NOP) when out_valid=0
- out_pc  out  32  head instruction byte address; 0 when out_valid=0
- trap  out  1  fetch halted on misaligned redirect
- trap_pc  out  32  offending redirect target; 0 when trap=0

## Operation
- State: pc (32b), buffer of 2 entries {pc, instr}, count (0..2), FSM state RUN/TRAP.
- Reset (rst_n=0): pc=RESET_PC, count=0, state=RUN, trap=0, trap_pc=0, out_valid=0, buffer storage cleared to 0.
- pop = out_valid & out_ready.
- push = (state==RUN) & ~redirect_valid & ((count<2) | pop). On push: write {pc, imem_rdata} to tail, pc <= pc + 4.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Buffer is FIFO; out_* reflect head entry (combinational from registered storage).
- Redirect (redirect_valid=1) has priority over push and pop: count <= 0 (flush, including an entry popped that cycle; the decode-side handshake still counts as accepted), pc <= redirect_pc, no push that cycle.
- Redirect with redirect_pc[1:0] != 0: pc loaded, state <= TRAP, trap_pc <= redirect_pc.
- TRAP: no pushes, buffer empty, trap=1, imem_addr still driven from pc. Leave TRAP only via an aligned redirect (state <= RUN, trap_pc <= 0) or reset. A misaligned redirect in TRAP updates trap_pc.
- pc arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. imem_addr ignores pc[31:AWIDTH+2] and pc[1:0] (address aliasing, no error).
- imem_addr = pc[AWIDTH+1:2] at all times, including reset.

## Timing
- Fetch latency: instruction at pc appears on out_* one cycle after the edge where it was pushed (i.e. first out_valid=1 in the first cycle after the first rising edge following reset release).
- Redirect-to-output latency: target instruction valid on out_* 2 cycles after the redirect cycle (redirect edge, then push edge).
- Throughput: 1 instruction/cycle with out_ready held high (steady state count=1, push+pop each cycle).
- Back-pressure: with out_ready=0, buffer fills to 2 within 2 cycles then pc holds; out_* stable while out_valid=1 & out_ready=0.
- Full + pop in same cycle: push still occurs; no bubble.
- trap rises one cycle after the misaligned redirect cycle; out_valid=0 from that same cycle.
- Asynchronous rst_n assertion mid-operation: all state returns to reset values immediately; in-flight entries discarded.

## Test plan
- Reset release, out_ready=1, ROM word k = 32'h1000_0000+k -> out_valid from first cycle after first edge; out_pc 0,4,8,… with out_instr 32'h1000_0000, 32'h1000_0001, … one per cycle.
- out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr stops at 2, out_pc=0 held; raise out_ready -> pcs 0,4,8,… delivered without gap or duplicate.
- Redirect to 32'h0000_0040 while buffer full and out_ready=1 -> buffer flushed, next valid out_pc=32'h40 exactly 2 cycles later, then 32'h44.
- Redirect to 32'h0000_0042 -> trap=1, trap_pc=32'h42, out_valid=0 persistent; then redirect to 32'h0000_0080 -> trap=0, out_pc=32'h80 two cycles later.
- Redirect to 32'hFFFF_FFFC with AWIDTH=8 -> imem_addr=8'hFF, out_pc FFFF_FFFC then 0 with imem_addr 0 (wrap).
- Assert rst_n low mid-stream with count=2 -> out_valid=0, trap=0, imem_addr=RESET_PC[AWIDTH+1:2] immediately without a clock edge.
